fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the hazard/pipeline control unit and the decode stage. It owns the program counter, drives the synchronous instruction-memory address, and presents the fetched instruction together with its PC to decode. It acts on the pc_inc / pc_load / pc_reset / imem_addr_mux / fetch_latch_stall strobes issued by pipeline control, and captures the interrupt return address.

Parameters:
PC_WIDTH, 10, width of program counter and instruction-memory address
INSTR_WIDTH, 18, width of an instruction word
RESET_VECTOR, 10'h000, PC value after either reset
INT_VECTOR, 10'h3FF, PC value loaded when pc_sel selects interrupt

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
pc_reset  in  1  synchronous reset request from pipeline control, active-high
pc_inc  in  1  advance PC by one
pc_load  in  1  load PC from source chosen by pc_sel
pc_sel  in  2  load source: 0 branch_target, 1 return_addr, 2 INT_VECTOR, 3 treated as 0
branch_target  in  PC_WIDTH  branch/call destination from decode/execute
return_addr  in  PC_WIDTH  return destination popped from stack
imem_addr_mux  in  1  1 = re-issue held address (addr_q) instead of pc
fetch_latch_stall  in  1  1 = hold addr_q and fetch_valid
imem_addr  out  PC_WIDTH  address to synchronous instruction ROM
imem_data  in  INSTR_WIDTH  ROM read data, valid one cycle after address
fetch_instr  out  INSTR_WIDTH  instruction to decode (= imem_data)
fetch_pc  out  PC_WIDTH  address of fetch_instr (= addr_q)
fetch_valid  out  1  fetch_instr is a live instruction
pc  out  PC_WIDTH  current program counter
int_ret_pc  out  PC_WIDTH  PC captured on interrupt-vector load

Behaviour:
- Reset (reset_n low, asynchronous): pc = RESET_VECTOR, addr_q = RESET_VECTOR, fetch_valid = 0, int_ret_pc = 0. imem_addr follows the mux and reads RESET_VECTOR.
- pc_reset high at a clock edge: same values as async reset. It has top priority over all other inputs.
- PC update priority per edge: pc_reset > pc_load > pc_inc > hold.
- pc_inc: pc <= pc + 1, modulo 2^PC_WIDTH (0x3FF wraps to 0x000).
- pc_load: pc <= the source selected by pc_sel. pc_sel==2 also sets int_ret_pc <= pc (the value before the load). In all other cycles int_ret_pc holds.
- Address mux (combinational): imem_addr = imem_addr_mux ? addr_q : pc.
- addr_q: if fetch_latch_stall, it holds. Otherwise addr_q <= imem_addr. This keeps fetch_pc aligned with the ROM output one cycle later.
- fetch_valid next value:
  - 0 if pc_reset or pc_load.
  - Else, hold if fetch_latch_stall.
  - Else 1.
- Latency: address A issued in cycle n gives fetch_instr = mem[A], fetch_pc = A, fetch_valid = 1 in cycle n+1.
- Stall (imem_addr_mux = fetch_latch_stall = 1, pc_inc = 0): ROM re-reads addr_q. fetch_instr, fetch_pc and fetch_valid are stable every stalled cycle. pc holds.
- Load during stall (return detection): pc loads, addr_q holds, fetch_valid <= 0. The first cycle after the stall releases issues the new pc.
- pc_inc and pc_load together: load wins, no increment. This is legal but not generated by control.
- No FSM is required beyond the registers above. The sequential state is pc, addr_q, fetch_valid and int_ret_pc.

Test Plan:
1. Pulse reset_n low mid-run with pc=0x123 -> pc, addr_q, imem_addr = 0x000 immediately (asynchronous); fetch_valid=0. After release with pc_inc=1, fetch_pc = 0,1,2 on successive cycles and fetch_valid=1 from the second cycle.
2. pc=0x3FE, pc_inc held for 3 cycles -> pc goes 0x3FF, 0x000, 0x001; imem_addr wraps correctly.
3. Run from 0x010, then assert imem_addr_mux + fetch_latch_stall for 2 cycles with pc_inc=0 -> imem_addr=0x010 twice; fetch_pc=0x010 and fetch_instr unchanged. After release the sequence resumes at 0x011 with no skipped or duplicated address.
4. pc=0x040, pc_load=1, pc_sel=0, branch_target=0x200 -> next cycle pc=0x200 and fetch_valid=0. The following cycle fetch_pc=0x200 and fetch_valid=1.
5. pc=0x055, pc_load=1, pc_sel=2 -> pc=0x3FF and int_ret_pc=0x055. A later pc_load with pc_sel=1, return_addr=0x055 gives pc=0x055 and int_ret_pc unchanged.
6. Assert pc_reset together with pc_load and pc_inc -> pc=RESET_VECTOR and fetch_valid=0. pc_sel=3 with branch_target=0x0AA loads 0x0AA.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the PC and the synchronous instruction-ROM address.
// Ports:
//   i_clk               rising-edge clock
//   i_reset_n           asynchronous active-low reset
//   i_pc_reset          synchronous reset request, top priority
//   i_pc_inc            advance pc by one (wraps)
//   i_pc_load           load pc from the source chosen by i_pc_sel
//   i_pc_sel            0/3 branch target, 1 return address, 2 interrupt vector
//   i_branch_target     branch/call destination
//   i_return_addr       return destination from the stack
//   i_imem_addr_mux     1 = re-issue the held address instead of pc
//   i_fetch_latch_stall 1 = hold the address latch and fetch_valid
//   o_imem_addr         address to the synchronous ROM
//   i_imem_data         ROM data, one cycle after the address
//   o_fetch_instr       instruction to decode
//   o_fetch_pc          address of o_fetch_instr
//   o_fetch_valid       o_fetch_instr is live
//   o_pc                current program counter
//   o_int_ret_pc        pc captured when the interrupt vector is loaded
module fetch_stage #(
    parameter int                     PC_WIDTH     = 10,
    parameter int                     INSTR_WIDTH  = 18,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 10'h000,
    parameter logic [PC_WIDTH-1:0]    INT_VECTOR   = 10'h3FF
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_pc_reset,
    input  logic                   i_pc_inc,
    input  logic                   i_pc_load,
    input  logic [1:0]             i_pc_sel,
    input  logic [PC_WIDTH-1:0]    i_branch_target,
    input  logic [PC_WIDTH-1:0]    i_return_addr,
    input  logic                   i_imem_addr_mux,
    input  logic                   i_fetch_latch_stall,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic [INSTR_WIDTH-1:0] o_fetch_instr,
    output logic [PC_WIDTH-1:0]    o_fetch_pc,
    output logic                   o_fetch_valid,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [PC_WIDTH-1:0]    o_int_ret_pc
);
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_addr_q;
    logic                r_fetch_valid;
    logic [PC_WIDTH-1:0] r_int_ret_pc;
    logic [PC_WIDTH-1:0] w_imem_addr;
    logic [PC_WIDTH-1:0] w_load_src;

    assign w_imem_addr = i_imem_addr_mux ? r_addr_q : r_pc;
    // pc_sel 3 falls back to the branch target
    assign w_load_src  = (i_pc_sel == 2'd1) ? i_return_addr :
                         (i_pc_sel == 2'd2) ? INT_VECTOR : i_branch_target;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc          <= RESET_VECTOR;
            r_addr_q      <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_int_ret_pc  <= '0;
        end else if (i_pc_reset) begin
            r_pc          <= RESET_VECTOR;
            r_addr_q      <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_int_ret_pc  <= '0;
        end else begin
            if (i_pc_load) begin
                r_pc <= w_load_src;
                if (i_pc_sel == 2'd2) r_int_ret_pc <= r_pc;
            end else if (i_pc_inc) begin
                r_pc <= r_pc + PC_WIDTH'(1);
            end
            // addr_q tracks the issued address so fetch_pc lines up with ROM data
            if (!i_fetch_latch_stall) r_addr_q <= w_imem_addr;
            r_fetch_valid <= i_pc_load ? 1'b0 : (i_fetch_latch_stall ? r_fetch_valid : 1'b1);
        end
    end

    assign o_imem_addr   = w_imem_addr;
    assign o_fetch_instr = i_imem_data;
    assign o_fetch_pc    = r_addr_q;
    assign o_fetch_valid = r_fetch_valid;
    assign o_pc          = r_pc;
    assign o_int_ret_pc  = r_int_ret_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_reset, pc_inc, pc_load, imem_addr_mux, fetch_latch_stall;
    logic [1:0]  pc_sel;
    logic [9:0]  branch_target, return_addr;
    logic [9:0]  imem_addr, fetch_pc, pc_o, int_ret_pc;
    logic [17:0] imem_data, fetch_instr;
    logic        fetch_valid;

    logic [17:0] mem [1024];
    int          m_pc, m_aq, m_fv, m_irp;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];

    fetch_stage dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_pc_reset(pc_reset), .i_pc_inc(pc_inc),
        .i_pc_load(pc_load), .i_pc_sel(pc_sel), .i_branch_target(branch_target),
        .i_return_addr(return_addr), .i_imem_addr_mux(imem_addr_mux),
        .i_fetch_latch_stall(fetch_latch_stall), .o_imem_addr(imem_addr),
        .i_imem_data(imem_data), .o_fetch_instr(fetch_instr), .o_fetch_pc(fetch_pc),
        .o_fetch_valid(fetch_valid), .o_pc(pc_o), .o_int_ret_pc(int_ret_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pc", 32'(pc_o), 32'(m_pc));
        check("fetch_pc", 32'(fetch_pc), 32'(m_aq));
        check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        check("int_ret_pc", 32'(int_ret_pc), 32'(m_irp));
        if (m_fv == 1) check("fetch_instr", 32'(fetch_instr), 32'(mem[m_aq]));
    endtask

    task automatic model_reset();
        m_pc = 0; m_aq = 0; m_fv = 0; m_irp = 0;
    endtask

    task automatic step(input logic rs, ld, inc, input logic [1:0] sel,
                        input logic [9:0] bt, ra, input logic mx, st);
        int issued;
        pc_reset = rs; pc_load = ld; pc_inc = inc; pc_sel = sel;
        branch_target = bt; return_addr = ra; imem_addr_mux = mx; fetch_latch_stall = st;
        #1;
        issued = mx ? m_aq : m_pc;
        check("imem_addr", 32'(imem_addr), 32'(issued));
        if (rs) model_reset();
        else begin
            if (ld) begin
                if (sel == 2) m_irp = m_pc;
                m_pc = (sel == 1) ? int'(ra) : (sel == 2) ? 'h3FF : int'(bt);
            end else if (inc) m_pc = (m_pc + 1) % 1024;
            if (!st) m_aq = issued;
            m_fv = ld ? 0 : (st ? m_fv : 1);
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic load_pc(input logic [9:0] a);
        step(0, 1, 0, 0, a, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
        reset_n = 1'b0; pc_reset = 0; pc_inc = 0; pc_load = 0; pc_sel = 0;
        branch_target = 0; return_addr = 0; imem_addr_mux = 0; fetch_latch_stall = 0;
        model_reset();
        #3;
        check_all();
        check("imem_addr_rst", 32'(imem_addr), 32'h0);
        #9 reset_n = 1'b1;
        @(posedge clk); #1;
        // async reset mid-run
        load_pc(10'h123);
        inc_n(2);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("imem_addr_async", 32'(imem_addr), 32'h0);
        #1 reset_n = 1'b1;
        inc_n(3);
        // wrap
        load_pc(10'h3FE);
        inc_n(3);
        // stall and resume
        load_pc(10'h010);
        inc_n(1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        inc_n(3);
        // branch
        load_pc(10'h040);
        inc_n(1);
        step(0, 1, 0, 0, 10'h200, 0, 0, 0);
        inc_n(2);
        // interrupt and return
        load_pc(10'h055);
        step(0, 1, 0, 2, 0, 0, 0, 0);
        inc_n(2);
        step(0, 1, 0, 1, 0, 10'h055, 0, 0);
        inc_n(1);
        // pc_reset priority, pc_sel 3, load+inc
        step(1, 1, 1, 2, 10'h1AB, 0, 0, 0);
        step(0, 1, 0, 3, 10'h0AA, 0, 0, 0);
        step(0, 1, 1, 0, 10'h300, 0, 0, 0);
        inc_n(1);
        // load during stall
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 10'h155, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        inc_n(2);
        // randomized traffic; stalls always re-issue the held address
        for (int i = 0; i < 600; i++) begin
            logic st;
            st = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 40) == 0, $urandom_range(0, 6) == 0, 1'($urandom),
                 2'($urandom), 10'($urandom), 10'($urandom),
                 st | ($urandom_range(0, 9) == 0), st);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
